// File: rtl/booth_session_arbiter.sv
// Round-robin arbiter that walks one booth at a time through authenticate, vote and result
// on the shared voting controller. Define SESSION_TIMEOUT_EN to bound the vote/result waits.
module booth_session_arbiter #(
    parameter int NUM_BOOTHS     = 4,
    parameter int ID_W           = 8,
    parameter int CAND_W         = 4,
    parameter int AUTH_LAT       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         system_enable,
    input  logic [NUM_BOOTHS-1:0]        booth_req,
    input  logic [NUM_BOOTHS*ID_W-1:0]   booth_voter_id,
    input  logic [NUM_BOOTHS*CAND_W-1:0] booth_candidate,
    input  logic [NUM_BOOTHS-1:0]        booth_submit,
    output logic [NUM_BOOTHS-1:0]        booth_grant,
    output logic                         booth_ack,
    output logic                         booth_nack,
    output logic [7:0]                   booth_err,
    output logic [2:0]                   active_booth,
    output logic                         busy,
    output logic [ID_W-1:0]              ctl_voter_id,
    output logic [CAND_W-1:0]            ctl_candidate,
    output logic                         ctl_authenticate,
    output logic                         ctl_submit,
    input  logic [7:0]                   ctl_system_status,
    input  logic                         ctl_vote_accepted,
    input  logic                         ctl_vote_rejected,
    input  logic [7:0]                   ctl_error_code,
    output logic [15:0]                  sessions_done
);

    if (NUM_BOOTHS < 2 || NUM_BOOTHS > 8 || AUTH_LAT < 1 || AUTH_LAT > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("booth_session_arbiter: parameter out of range");
    end

    localparam logic [7:0] STATUS_AUTH_OK = 8'h01;
    localparam logic [7:0] ERR_AUTH       = 8'h01;
    localparam logic [7:0] ERR_TIMEOUT    = 8'hFE;
    localparam logic [7:0] ERR_DISABLED   = 8'hFD;

    typedef enum logic [2:0] {
        IDLE, AUTH, AUTH_WAIT, VOTE_WAIT, SUBMIT, RESULT_WAIT, RELEASE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_BOOTHS-1:0]   grant_q, grant_d;
    logic [NUM_BOOTHS-1:0]   sess_q, sess_d;
    logic [2:0]              active_q, active_d;
    logic [2:0]              ptr_q, ptr_d;
    logic [3:0]              wait_q, wait_d;
    logic [ID_W-1:0]         ctl_id_q, ctl_id_d;
    logic [CAND_W-1:0]       ctl_cand_q, ctl_cand_d;
    logic                    ctl_auth_q, ctl_auth_d;
    logic                    ctl_sub_q, ctl_sub_d;
    logic                    ack_q, ack_d;
    logic                    nack_q, nack_d;
    logic [7:0]              err_q, err_d;
    logic [15:0]             done_q, done_d;

    logic                    found;
    logic [2:0]              sel;
    logic [NUM_BOOTHS-1:0]   sel_oh;
    logic [ID_W-1:0]         id_sel;
    logic [CAND_W-1:0]       cand_sel;
    logic                    gnt_req;
    logic                    gnt_sub;
    logic [2:0]              next_ptr;
    logic                    to_release;
    logic                    timeout_hit;

`ifdef SESSION_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q, to_cnt_d;
    assign timeout_hit = (to_cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Wrap-around search: first requester at or after the pointer, then from booth 0.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        sel_oh = '0;
        id_sel = '0;
        for (int k = 0; k < NUM_BOOTHS; k++) begin
            if (!found && booth_req[k] && k >= int'(ptr_q)) begin
                found     = 1'b1;
                sel       = 3'(k);
                sel_oh[k] = 1'b1;
                id_sel    = booth_voter_id[k*ID_W +: ID_W];
            end
        end
        for (int k = 0; k < NUM_BOOTHS; k++) begin
            if (!found && booth_req[k]) begin
                found     = 1'b1;
                sel       = 3'(k);
                sel_oh[k] = 1'b1;
                id_sel    = booth_voter_id[k*ID_W +: ID_W];
            end
        end
    end

    // sess_q keeps the session's one-hot after booth_grant is cleared in RELEASE.
    always_comb begin
        cand_sel = '0;
        for (int k = 0; k < NUM_BOOTHS; k++) begin
            if (sess_q[k]) cand_sel = booth_candidate[k*CAND_W +: CAND_W];
        end
    end

    assign gnt_req  = |(booth_req & sess_q);
    assign gnt_sub  = |(booth_submit & sess_q);
    assign next_ptr = (active_q == 3'(NUM_BOOTHS - 1)) ? 3'd0 : active_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sess_d     = sess_q;
        active_d   = active_q;
        ptr_d      = ptr_q;
        wait_d     = wait_q;
        ctl_id_d   = ctl_id_q;
        ctl_cand_d = ctl_cand_q;
        ctl_auth_d = 1'b0;
        ctl_sub_d  = 1'b0;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
        err_d      = err_q;
        done_d     = done_q;
        to_release = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (system_enable && found) begin
                    state_d    = AUTH;
                    grant_d    = sel_oh;
                    sess_d     = sel_oh;
                    active_d   = sel;
                    ctl_id_d   = id_sel;
                    ctl_auth_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!gnt_req) state_d = IDLE;
            end
            default: begin
                // Abort conditions outrank every in-session transition.
                if (!system_enable) begin
                    nack_d     = 1'b1;
                    err_d      = ERR_DISABLED;
                    to_release = 1'b1;
                end else if (!gnt_req) begin
                    to_release = 1'b1;
                end else begin
                    case (state_q)
                        AUTH: begin
                            state_d = AUTH_WAIT;
                            wait_d  = 4'(AUTH_LAT);
                        end
                        AUTH_WAIT: begin
                            if (ctl_vote_rejected) begin
                                nack_d     = 1'b1;
                                err_d      = ctl_error_code;
                                to_release = 1'b1;
                            end else if (wait_q <= 4'd1) begin
                                if (ctl_system_status == STATUS_AUTH_OK) begin
                                    state_d = VOTE_WAIT;
                                end else begin
                                    nack_d     = 1'b1;
                                    err_d      = ERR_AUTH;
                                    to_release = 1'b1;
                                end
                            end else begin
                                wait_d = wait_q - 4'd1;
                            end
                        end
                        VOTE_WAIT: begin
                            if (gnt_sub) begin
                                ctl_cand_d = cand_sel;
                                ctl_sub_d  = 1'b1;
                                state_d    = SUBMIT;
                            end else if (timeout_hit) begin
                                nack_d     = 1'b1;
                                err_d      = ERR_TIMEOUT;
                                to_release = 1'b1;
                            end
                        end
                        SUBMIT: state_d = RESULT_WAIT;
                        RESULT_WAIT: begin
                            if (ctl_vote_rejected) begin
                                nack_d     = 1'b1;
                                err_d      = ctl_error_code;
                                to_release = 1'b1;
                            end else if (ctl_vote_accepted) begin
                                ack_d      = 1'b1;
                                done_d     = done_q + 16'd1;
                                to_release = 1'b1;
                            end else if (timeout_hit) begin
                                nack_d     = 1'b1;
                                err_d      = ERR_TIMEOUT;
                                to_release = 1'b1;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        if (to_release) begin
            state_d = RELEASE;
            grant_d = '0;
            ptr_d   = next_ptr;
        end

`ifdef SESSION_TIMEOUT_EN
        // Restarts on every state change, so it counts from entry into the current phase.
        to_cnt_d = (state_d != state_q) ? 16'd0 : to_cnt_q + 16'd1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sess_q     <= '0;
            active_q   <= '0;
            ptr_q      <= '0;
            wait_q     <= '0;
            ctl_id_q   <= '0;
            ctl_cand_q <= '0;
            ctl_auth_q <= 1'b0;
            ctl_sub_q  <= 1'b0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            err_q      <= '0;
            done_q     <= '0;
`ifdef SESSION_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sess_q     <= sess_d;
            active_q   <= active_d;
            ptr_q      <= ptr_d;
            wait_q     <= wait_d;
            ctl_id_q   <= ctl_id_d;
            ctl_cand_q <= ctl_cand_d;
            ctl_auth_q <= ctl_auth_d;
            ctl_sub_q  <= ctl_sub_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            err_q      <= err_d;
            done_q     <= done_d;
`ifdef SESSION_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign booth_grant      = grant_q;
    assign booth_ack        = ack_q;
    assign booth_nack       = nack_q;
    assign booth_err        = err_q;
    assign active_booth     = active_q;
    assign busy             = (state_q != IDLE);
    assign ctl_voter_id     = ctl_id_q;
    assign ctl_candidate    = ctl_cand_q;
    assign ctl_authenticate = ctl_auth_q;
    assign ctl_submit       = ctl_sub_q;
    assign sessions_done    = done_q;

endmodule

// File: tb/tb_booth_session_arbiter.sv
// Self-checking bench for booth_session_arbiter: directed sessions plus randomized ones
// against a round-robin / outcome model. SESSION_TIMEOUT_EN adds the timeout session.
module tb_booth_session_arbiter;
    localparam int NB       = 4;
    localparam int ID_W     = 8;
    localparam int CAND_W   = 4;
    localparam int AUTH_LAT = 2;
    localparam int TO       = 10;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   system_enable;
    logic [NB-1:0]          booth_req;
    logic [NB*ID_W-1:0]     booth_voter_id;
    logic [NB*CAND_W-1:0]   booth_candidate;
    logic [NB-1:0]          booth_submit;
    logic [NB-1:0]          booth_grant;
    logic                   booth_ack;
    logic                   booth_nack;
    logic [7:0]             booth_err;
    logic [2:0]             active_booth;
    logic                   busy;
    logic [ID_W-1:0]        ctl_voter_id;
    logic [CAND_W-1:0]      ctl_candidate;
    logic                   ctl_authenticate;
    logic                   ctl_submit;
    logic [7:0]             ctl_system_status;
    logic                   ctl_vote_accepted;
    logic                   ctl_vote_rejected;
    logic [7:0]             ctl_error_code;
    logic [15:0]            sessions_done;

    booth_session_arbiter #(
        .NUM_BOOTHS(NB), .ID_W(ID_W), .CAND_W(CAND_W), .AUTH_LAT(AUTH_LAT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .system_enable(system_enable),
        .booth_req(booth_req), .booth_voter_id(booth_voter_id),
        .booth_candidate(booth_candidate), .booth_submit(booth_submit),
        .booth_grant(booth_grant), .booth_ack(booth_ack), .booth_nack(booth_nack),
        .booth_err(booth_err), .active_booth(active_booth), .busy(busy),
        .ctl_voter_id(ctl_voter_id), .ctl_candidate(ctl_candidate),
        .ctl_authenticate(ctl_authenticate), .ctl_submit(ctl_submit),
        .ctl_system_status(ctl_system_status), .ctl_vote_accepted(ctl_vote_accepted),
        .ctl_vote_rejected(ctl_vote_rejected), .ctl_error_code(ctl_error_code),
        .sessions_done(sessions_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ptr_m = 0;
    int done_m = 0;
    logic [7:0] err_m = 8'h00;
    int last_wait;
    int obs_g;
    logic [ID_W-1:0] ids [NB];
    int order_a [4] = '{0, 1, 2, 3};
    int order_b [4] = '{2, 3, 0, 1};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester scanning upward from the pointer, modulo NB.
    function automatic int rr_pick(input logic [NB-1:0] m, input int p);
        for (int k = 0; k < NB; k++) begin
            if (m[(p + k) % NB]) return (p + k) % NB;
        end
        return -1;
    endfunction

    task automatic pack_ids();
        for (int i = 0; i < NB; i++) booth_voter_id[i*ID_W +: ID_W] = ids[i];
    endtask

    task automatic randomize_ids();
        for (int i = 0; i < NB; i++) ids[i] = ID_W'($urandom);
        pack_ids();
    endtask

    // scen: 0 accept, 1 auth reject, 2 bad auth status, 3 vote reject, 4 enable drop,
    //       5 request drop (abort), 6 accept+reject together, 7 vote timeout
    task automatic do_session(input int scen, input logic [7:0] code, input logic [CAND_W-1:0] cand);
        int g;
        int n;
        int d;
        g = rr_pick(booth_req, ptr_m);
        n = 0;
        while (ctl_authenticate !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        last_wait = n;
        obs_g = int'(active_booth);
        check("auth_pulse", 32'(ctl_authenticate), 1);
        check("grant_onehot", 32'(booth_grant), 32'(1) << g);
        check("active_booth", 32'(active_booth), 32'(g));
        check("voter_id", 32'(ctl_voter_id), 32'(ids[g]));
        check("busy_in_session", 32'(busy), 1);
        ctl_system_status = (scen == 2) ? 8'(($urandom_range(0, 1) == 0) ? 8'h00 : 8'h05) : 8'h01;
        booth_submit = NB'(1) << g;
        tick();
        booth_submit = '0;
        check("auth_one_cycle", 32'(ctl_authenticate), 0);
        if (scen == 1) begin
            ctl_vote_rejected = 1'b1;
            ctl_error_code = code;
            tick();
            ctl_vote_rejected = 1'b0;
            check("auth_rej_nack", 32'(booth_nack), 1);
            check("auth_rej_err", 32'(booth_err), 32'(code));
            check("auth_rej_no_submit", 32'(ctl_submit), 0);
            err_m = code;
        end else begin
            repeat (AUTH_LAT) tick();
            if (scen == 2) begin
                check("auth_fail_nack", 32'(booth_nack), 1);
                check("auth_fail_err", 32'(booth_err), 32'h01);
                err_m = 8'h01;
            end else begin
                check("vote_wait_no_nack", 32'(booth_nack), 0);
                check("vote_wait_grant", 32'(booth_grant), 32'(1) << g);
                check("early_submit_ignored", 32'(ctl_submit), 0);
                if (scen != 7) begin
                    d = $urandom_range(0, 2);
                    repeat (d) begin
                        booth_submit = NB'($urandom) & ~(NB'(1) << g);
                        tick();
                        check("foreign_submit_ignored", 32'(ctl_submit), 0);
                    end
                    booth_submit = '0;
                end
                if (scen == 4) begin
                    system_enable = 1'b0;
                    tick();
                    check("disable_nack", 32'(booth_nack), 1);
                    check("disable_err", 32'(booth_err), 32'hFD);
                    check("disable_grant_clear", 32'(booth_grant), 0);
                    err_m = 8'hFD;
                    booth_req = ~(NB'(1) << g);
                    tick();
                    repeat (3) begin
                        tick();
                        check("disabled_no_grant", 32'(booth_grant), 0);
                        check("disabled_idle", 32'(busy), 0);
                    end
                    system_enable = 1'b1;
                    booth_req = '0;
                end else if (scen == 5) begin
                    booth_req[g] = 1'b0;
                    tick();
                    check("abort_grant_clear", 32'(booth_grant), 0);
                    check("abort_no_nack", 32'(booth_nack), 0);
                    check("abort_no_ack", 32'(booth_ack), 0);
                    check("abort_release_busy", 32'(busy), 1);
                    tick();
                    check("abort_idle", 32'(busy), 0);
                end else if (scen == 7) begin
                    repeat (TO - 1) begin
                        tick();
                        check("timeout_not_yet", 32'(booth_nack), 0);
                    end
                    tick();
                    check("timeout_nack", 32'(booth_nack), 1);
                    check("timeout_err", 32'(booth_err), 32'hFE);
                    err_m = 8'hFE;
                end else begin
                    booth_candidate = (NB*CAND_W)'($urandom);
                    booth_candidate[g*CAND_W +: CAND_W] = cand;
                    booth_submit = NB'(1) << g;
                    tick();
                    check("ctl_submit_pulse", 32'(ctl_submit), 1);
                    check("ctl_candidate", 32'(ctl_candidate), 32'(cand));
                    booth_submit = ($urandom_range(0, 1) == 1) ? (NB'(1) << g) : '0;
                    tick();
                    booth_submit = '0;
                    check("ctl_submit_one_cycle", 32'(ctl_submit), 0);
                    d = $urandom_range(0, 2);
                    repeat (d) begin
                        tick();
                        check("result_wait_no_ack", 32'(booth_ack | booth_nack), 0);
                    end
                    ctl_vote_accepted = (scen == 0 || scen == 6);
                    ctl_vote_rejected = (scen == 3 || scen == 6);
                    ctl_error_code = code;
                    tick();
                    ctl_vote_accepted = 1'b0;
                    ctl_vote_rejected = 1'b0;
                    if (scen == 0) begin
                        done_m = (done_m + 1) % 65536;
                        check("accept_ack", 32'(booth_ack), 1);
                        check("accept_no_nack", 32'(booth_nack), 0);
                    end else begin
                        check("reject_nack", 32'(booth_nack), 1);
                        check("reject_no_ack", 32'(booth_ack), 0);
                        check("reject_err", 32'(booth_err), 32'(code));
                        err_m = code;
                    end
                    check("sessions_done", 32'(sessions_done), 32'(done_m));
                end
            end
        end
        if (scen != 4 && scen != 5) begin
            check("release_grant_clear", 32'(booth_grant), 0);
            check("release_busy", 32'(busy), 1);
            d = $urandom_range(1, 2);
            repeat (d) begin
                tick();
                check("release_hold_busy", 32'(busy), 1);
                check("release_pulses_done", 32'(booth_ack | booth_nack), 0);
            end
            booth_req[g] = 1'b0;
            tick();
            check("release_to_idle", 32'(busy), 0);
        end
        ctl_system_status = 8'h00;
        ptr_m = (g + 1) % NB;
        check("err_held", 32'(booth_err), 32'(err_m));
        check("done_held", 32'(sessions_done), 32'(done_m));
    endtask

    initial begin
        reset = 1'b1;
        system_enable = 1'b1;
        booth_req = '0;
        booth_submit = '0;
        booth_candidate = '0;
        ctl_system_status = 8'h00;
        ctl_vote_accepted = 1'b0;
        ctl_vote_rejected = 1'b0;
        ctl_error_code = 8'h00;
        for (int i = 0; i < NB; i++) ids[i] = ID_W'(8'h10 + i);
        pack_ids();
        repeat (2) tick();
        check("rst_grant", 32'(booth_grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outputs", 32'({booth_ack, booth_nack, ctl_authenticate, ctl_submit}), 0);
        check("rst_err", 32'(booth_err), 0);
        check("rst_done", 32'(sessions_done), 0);
        check("rst_ctl_id", 32'(ctl_voter_id), 0);
        reset = 1'b0;
        tick();

        // Single accepted session from booth 0
        ids[0] = 8'h12;
        pack_ids();
        booth_req = 4'b0001;
        do_session(0, 8'h00, 4'd2);
        check("t1_req_to_auth", 32'(last_wait), 1);
        check("t1_done_one", 32'(sessions_done), 1);

        // Round-robin from pointer 0, then from pointer 2
        booth_req = 4'b1000;
        do_session(0, 8'h00, 4'd1);
        booth_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            do_session(0, 8'h00, CAND_W'(i));
            check("rr_order_ptr0", 32'(obs_g), 32'(order_a[i]));
        end
        booth_req = 4'b0010;
        do_session(0, 8'h00, 4'd3);
        booth_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            do_session(0, 8'h00, CAND_W'(i + 4));
            check("rr_order_ptr2", 32'(obs_g), 32'(order_b[i]));
        end

        // Directed error paths
        booth_req = 4'b0001;
        do_session(1, 8'h02, 4'd0);
        booth_req = 4'b0001;
        do_session(3, 8'h03, 4'd5);
        booth_req = 4'b0100;
        do_session(4, 8'h00, 4'd1);
        booth_req = 4'b0010;
        do_session(2, 8'h00, 4'd1);
        booth_req = 4'b1000;
        do_session(5, 8'h00, 4'd1);
        booth_req = 4'b0001;
        do_session(6, 8'h07, 4'd9);
`ifdef SESSION_TIMEOUT_EN
        booth_req = 4'b0001;
        do_session(7, 8'h00, 4'd0);
`endif

        // Randomized sessions, with leftover requests competing across sessions
        for (int s = 0; s < 30; s++) begin
            if (booth_req == '0) booth_req = NB'($urandom_range(1, (1 << NB) - 1));
            randomize_ids();
            do_session($urandom_range(0, 6), 8'($urandom), CAND_W'($urandom));
        end

        // Reset in the middle of the authentication window
        booth_req = 4'b0100;
        randomize_ids();
        begin
            int n;
            n = 0;
            while (ctl_authenticate !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
        end
        check("mid_grant", 32'(booth_grant), 32'(1) << rr_pick(4'b0100, ptr_m));
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_grant", 32'(booth_grant), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_pulses", 32'({booth_ack, booth_nack, ctl_authenticate, ctl_submit}), 0);
        check("mid_rst_err", 32'(booth_err), 0);
        check("mid_rst_done", 32'(sessions_done), 0);
        check("mid_rst_ctl", 32'({ctl_voter_id, ctl_candidate}), 0);
        check("mid_rst_active", 32'(active_booth), 0);
        tick();
        reset = 1'b0;
        booth_req = '0;
        ptr_m = 0;
        done_m = 0;
        err_m = 8'h00;
        tick();
        booth_req = 4'b1010;
        do_session(0, 8'h00, 4'd6);
        check("post_rst_ptr0_pick", 32'(obs_g), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
